// File: rtl/systolic_feeder.sv
// Operand sequencer for a 4x4 output-stationary systolic array: buffers one A/B
// tile over valid/ready, then drives skewed, zero-padded west/north operand streams.
module systolic_feeder #(
  parameter int DW    = 16,
  parameter int DRAIN = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [4*DW-1:0] in_a_i,
  input  logic [4*DW-1:0] in_b_i,
  output logic [DW-1:0] a1_o,
  output logic [DW-1:0] a2_o,
  output logic [DW-1:0] a3_o,
  output logic [DW-1:0] a4_o,
  output logic [DW-1:0] b1_o,
  output logic [DW-1:0] b2_o,
  output logic [DW-1:0] b3_o,
  output logic [DW-1:0] b4_o,
  output logic          feed_valid_o,
  output logic          acc_clr_o,
  output logic          done_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_LOAD, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e        state_q;
  logic [1:0]    k_q;
  logic [2:0]    t_q;
  logic [3:0]    drain_q;
  logic [DW-1:0] a_buf_q [4][4];  // a_buf_q[row][k]
  logic [DW-1:0] b_buf_q [4][4];  // b_buf_q[k][col]
  logic [DW-1:0] a_q [4];
  logic [DW-1:0] b_q [4];
  logic [DW-1:0] a_d [4];
  logic [DW-1:0] b_d [4];
  logic [2:0]    t_sel;
  logic          in_ready_q, feed_valid_q, acc_clr_q, done_q, busy_q;

  // Skewed operands for the step about to be presented: row/column i lags by i cycles.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    t_sel = (state_q == S_CLEAR) ? 3'd0 : t_q + 3'd1;
    for (int i = 0; i < 4; i++) begin
      a_d[i] = '0;
      b_d[i] = '0;
      for (int d = 0; d < 4; d++) begin
        if (int'(t_sel) == i + d) begin
          a_d[i] = a_buf_q[i][d];
          b_d[i] = b_buf_q[d][i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= S_LOAD;
      k_q          <= '0;
      t_q          <= '0;
      drain_q      <= '0;
      in_ready_q   <= 1'b1;
      feed_valid_q <= 1'b0;
      acc_clr_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      // NOTE: the operand buffer is reset too, so an aborted tile leaves no stale data.
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        for (int j = 0; j < 4; j++) begin
          a_buf_q[i][j] <= '0;
          b_buf_q[i][j] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid_i && in_ready_q) begin
            for (int i = 0; i < 4; i++) begin
              a_buf_q[i][k_q] <= in_a_i[DW*i +: DW];
              b_buf_q[k_q][i] <= in_b_i[DW*i +: DW];
            end
            if (k_q == 2'd3) begin
              state_q    <= S_CLEAR;
              k_q        <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              acc_clr_q  <= 1'b1;
            end else begin
              k_q <= k_q + 2'd1;
            end
          end
        end
        S_CLEAR: begin
          state_q      <= S_STREAM;
          t_q          <= '0;
          acc_clr_q    <= 1'b0;
          feed_valid_q <= 1'b1;
          a_q          <= a_d;
          b_q          <= b_d;
        end
        S_STREAM: begin
          if (t_q == 3'd6) begin
            state_q      <= S_DRAIN;
            drain_q      <= '0;
            feed_valid_q <= 1'b0;
            a_q          <= '{default: '0};
            b_q          <= '{default: '0};
          end else begin
            t_q <= t_q + 3'd1;
            a_q <= a_d;
            b_q <= b_d;
          end
        end
        S_DRAIN: begin
          if (drain_q == 4'(DRAIN - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        S_DONE: begin
          state_q    <= S_LOAD;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign feed_valid_o = feed_valid_q;
  assign acc_clr_o    = acc_clr_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign a1_o = a_q[0];
  assign a2_o = a_q[1];
  assign a3_o = a_q[2];
  assign a4_o = a_q[3];
  assign b1_o = b_q[0];
  assign b2_o = b_q[1];
  assign b3_o = b_q[2];
  assign b4_o = b_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: the driver pushes the expected clear/stream/done
// events per tile; a negedge monitor pops and compares whenever the DUT presents one.
module tb_systolic_feeder;

  localparam int K_CLR  = 0;
  localparam int K_STR  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid1 = 1'b0;
  logic [63:0] in_a = '0, in_b = '0;
  logic        in_ready, feed_valid, acc_clr, done, busy;
  logic [15:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic        in_ready1, feed_valid1, acc_clr1, done1, busy1;
  logic [15:0] x1, x2, x3, x4, y1, y2, y3, y4;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   last_l, first_hs;
  exp_t exp_q[$];
  logic [15:0] ta [4][4];
  logic [15:0] tbm [4][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_feeder #(.DW(16), .DRAIN(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b),
    .a1_o(a1), .a2_o(a2), .a3_o(a3), .a4_o(a4),
    .b1_o(b1), .b2_o(b2), .b3_o(b3), .b4_o(b4),
    .feed_valid_o(feed_valid), .acc_clr_o(acc_clr), .done_o(done), .busy_o(busy)
  );

  systolic_feeder #(.DW(16), .DRAIN(1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .in_a_i(in_a), .in_b_i(in_b),
    .a1_o(x1), .a2_o(x2), .a3_o(x3), .a4_o(x4),
    .b1_o(y1), .b2_o(y2), .b3_o(y3), .b4_o(y4),
    .feed_valid_o(feed_valid1), .acc_clr_o(acc_clr1), .done_o(done1), .busy_o(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_event kind %0d @cyc %0d: no event was due", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_cycle", 64'(cyc), 64'(e.cyc));
      check("west_ops", a, e.a);
      check("north_ops", b, e.b);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_clr) expect_evt(K_CLR, {a4, a3, a2, a1}, {b4, b3, b2, b1});
      if (feed_valid) expect_evt(K_STR, {a4, a3, a2, a1}, {b4, b3, b2, b1});
      else begin
        check("idle_west_zero", {a4, a3, a2, a1}, 64'd0);
        check("idle_north_zero", {b4, b3, b2, b1}, 64'd0);
      end
      if (done) expect_evt(K_DONE, '0, '0);
    end
  end

  task automatic set_default();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ta[i][j]  = 16'h0A00 + 16'(16 * i + j);
        tbm[i][j] = 16'h0B00 + 16'(16 * i + j);
      end
  endtask

  task automatic set_alt();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ta[i][j]  = 16'hC000 + 16'(i * 37 + j * 5);
        tbm[i][j] = 16'h5A5A ^ 16'(i * 256 + j * 17);
      end
  endtask

  task automatic push_exp(input int l, input int drain);
    exp_t e;
    e.kind = K_CLR; e.cyc = l + 1; e.a = '0; e.b = '0;
    exp_q.push_back(e);
    for (int t = 0; t < 7; t++) begin
      e.kind = K_STR; e.cyc = l + 2 + t; e.a = '0; e.b = '0;
      for (int i = 0; i < 4; i++) begin
        if (t - i >= 0 && t - i <= 3) begin
          e.a[16*i +: 16] = ta[i][t-i];
          e.b[16*i +: 16] = tbm[t-i][i];
        end
      end
      exp_q.push_back(e);
    end
    e.kind = K_DONE; e.cyc = l + 9 + drain; e.a = '0; e.b = '0;
    exp_q.push_back(e);
  endtask

  // vpat gives in_valid per cycle (LSB first) for plen cycles, then stays high.
  task automatic load_tile(input logic [15:0] vpat, input int plen);
    int k = 0;
    int idx = 0;
    while (k < 4 && idx < 200) begin
      in_valid = (idx < plen) ? vpat[idx] : 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_a[16*i +: 16] = ta[i][k];
        in_b[16*i +: 16] = tbm[k][i];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (k == 0) first_hs = cyc;
        if (k == 3) last_l = cyc;
        k++;
      end
      @(posedge clk); #1;
      idx++;
    end
    in_valid = 1'b0;
    if (k < 4) check("load_timeout_beats", 64'(k), 64'd4);
    else push_exp(last_l, 4);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (g >= 100) check("drain_timeout_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int l_bp, l1, done_cyc, k1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flags", {61'd0, feed_valid, acc_clr, done}, 64'd0);
    @(posedge clk); #1;

    // Basic skew, back-to-back beats.
    set_default();
    load_tile(16'h0000, 0);
    check("basic_beats_contiguous", 64'(last_l - first_hs), 64'd3);
    wait_idle();

    // Gapped beats 1,0,0,1,1,0,1,1.
    load_tile(16'h00D9, 8);
    check("gapped_last_beat_slot", 64'(last_l - first_hs), 64'd6);
    wait_idle();

    // Back-pressure: in_valid held high with changing data across the whole tile.
    set_alt();
    load_tile(16'h0000, 0);
    l_bp = last_l;
    in_valid = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_busy_high", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    set_default();
    load_tile(16'h0000, 0);
    check("bp_next_beat0_cycle", 64'(first_hs), 64'(l_bp + 14));
    wait_idle();

    // Reset at t=3 of the stream.
    set_alt();
    load_tile(16'h0000, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ops", {a4, a3, a2, a1, b4, b3, b2, b1} == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    check("midrst_flags", {60'd0, feed_valid, acc_clr, done, busy}, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    set_default();
    load_tile(16'h0000, 0);
    wait_idle();

    // DRAIN=1 instance: done at L+10, next beat 0 accepted at L+11.
    k1 = 0;
    l1 = 0;
    in_valid1 = 1'b1;
    for (int g = 0; g < 50 && k1 < 4; g++) begin
      @(negedge clk);
      if (in_ready1) begin
        if (k1 == 3) l1 = cyc;
        k1++;
      end
      @(posedge clk); #1;
    end
    check("d1_beats_loaded", 64'(k1), 64'd4);
    done_cyc = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done1 && done_cyc < 0) done_cyc = cyc;
      if (cyc == l1 + 10) check("d1_ready_at_done", 64'(in_ready1), 64'd0);
      if (cyc == l1 + 11) check("d1_accept_next_beat", 64'(in_ready1), 64'd1);
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    check("d1_done_cycle", 64'(done_cyc), 64'(l1 + 10));

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer that drives the 4x4 output-stationary systolic array (`array4x4`). It accepts one 4x4 tile of A and one 4x4 tile of B over a valid/ready interface and buffers them. It then emits skewed, zero-padded operand streams on the array's west (`a1..a4`) and north (`b1..b4`) edges, and signals when the array's `c1..c16` accumulators hold the finished product. It sits between the tile-fetch logic and the array and is the transmit end of the array's operand interface.

## Interface
- `DW`, 16: operand width; matches the array's 16-bit operand ports.
- `DRAIN`, 4: zero-padded flush cycles after streaming, before `done`. Legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: beat valid from the tile source.
- `in_ready` out 1: feeder can accept a beat.
- `in_a` in 4*DW: column k of A; lane i (`[DW*i +: DW]`) = A[i][k].
- `in_b` in 4*DW: row k of B; lane j = B[k][j].
- `a1..a4` out DW each: west-edge operands, rows 0..3.
- `b1..b4` out DW each: north-edge operands, columns 0..3.
- `feed_valid` out 1: high while skewed operands are being driven.
- `acc_clr` out 1: one-cycle pulse; integration uses it to clear the array accumulators.
- `done` out 1: one-cycle pulse; `c1..c16` are final.
- `busy` out 1: high in every state except LOAD.

## Operation
- **Beat transfer.** A beat transfers when `in_valid && in_ready`. The beat index k counts 0..3. Beat k writes A[0..3][k] and B[k][0..3] into a 32-entry register buffer.
- **LOAD.** `in_ready`=1.
  - The 4th handshake (k=3) moves the FSM to CLEAR and resets k to 0.
  - `in_valid` may drop between beats; k holds its value while it is low.
- **CLEAR.** Lasts 1 cycle. `acc_clr`=1 and all operand outputs are 0. Next state is STREAM with t=0.
- **STREAM.** Lasts 7 cycles, t=0..6, with `feed_valid`=1.
  - `a(i+1)` = A[i][t-i] when 0 ≤ t-i ≤ 3, else 0.
  - `b(j+1)` = B[t-j][j] when 0 ≤ t-j ≤ 3, else 0.
  - After t=6, next state is DRAIN.
- **DRAIN.** Lasts `DRAIN` cycles. All operand outputs are 0 and `feed_valid`=0. Next state is DONE.
- **DONE.** Lasts 1 cycle with `done`=1. Next state is LOAD. The buffer is not cleared; the next tile's beats overwrite it.
- **Outputs.**
  - All outputs are registered.
  - Operand outputs are 0 in every state other than STREAM.
  - No arithmetic is performed; operands pass through bit-exact.
- **Reset mid-operation.** Asserting `rst` in any state aborts the tile:
  - FSM goes to LOAD; k, t and the drain counter go to 0; buffer entries go to 0.
  - No `done` is issued for the aborted tile.

## Timing
- **Reset values.**
  - `in_ready`=1 from the first cycle after `rst` deasserts.
  - `a1..a4`, `b1..b4`, `feed_valid`, `acc_clr`, `done` = 0.
  - `busy`=0.
- **Schedule.** Let L be the cycle of the 4th handshake.
  - CLEAR at L+1.
  - STREAM at L+2..L+8 (t = cycle − (L+2)).
  - DRAIN at L+9..L+8+DRAIN.
  - DONE at L+9+DRAIN (L+13 at default).
  - LOAD again at L+10+DRAIN.
- **Back-pressure.** `in_ready`=0 from L+1 through the DONE cycle inclusive. `in_valid` is ignored while `in_ready`=0.
- **Throughput.** The minimum tile period is 4 + 1 + 7 + DRAIN + 1 cycles (17 at default).
- **Timing closure.** No combinational path runs from `in_valid` to `in_ready`.

## Test plan
All scenarios load tiles with A[i][k]=0x0A00+16i+k and B[k][j]=0x0B00+16k+j, unless a scenario gives other values.

- **Basic skew.** Load 4 back-to-back beats, K = L.
  - L+1: `acc_clr`=1.
  - t=0: `a1`=0x0A00, `b1`=0x0B00, all other operands 0.
  - t=3: `a1..a4`=0x0A03/0x0A12/0x0A21/0x0A30 and `b1..b4`=0x0B30/0x0B21/0x0B12/0x0B03.
  - t=6: `a4`=0x0A33, `b4`=0x0B33, all others 0.
  - `done` at L+13.
- **Gapped beats.** Toggle `in_valid` 1,0,0,1,1,0,1,1 → the same stream values as basic skew; CLEAR follows exactly one cycle after the 4th handshake.
- **Back-pressure.** Hold `in_valid`=1 with changing data throughout a tile → `in_ready`=0 from L+1 to L+13. The values driven in that window are not captured; the next tile's beat 0 is accepted at L+14.
- **End-to-end.** Connect to `array4x4` and apply identity A with B as above → `c1..c16` equal B[i][j] when `done` is high.
- **Reset mid-stream.** Pull `rst` low at t=3 → all outputs return to reset values immediately and no `done` pulse is issued. After release, `in_ready`=1 and a fresh tile streams correctly.
- **Parameter.** With `DRAIN`=1 → `done` at L+10 and the next tile's beat 0 is accepted at L+11.
